// File: rtl/rate_divider_if.sv
// rate_divider_if: control and status bundle of the programmable rate divider
interface rate_divider_if #(parameter int W = 16);
  logic en;
  logic restart;
  logic load;
  logic mode_in;
  logic [W-1:0] div_in;
  logic [W-1:0] inc_in;
  logic load_busy;
  logic tick;
  logic sq;
  logic [W-1:0] phase;
  modport master (output en, restart, load, mode_in, div_in, inc_in,
                  input load_busy, tick, sq, phase);
  modport slave (input en, restart, load, mode_in, div_in, inc_in,
                 output load_busy, tick, sq, phase);
endinterface

// File: rtl/rate_divider.sv
// rate_divider: integer / NCO clock-enable generator with boundary-applied shadow settings
module rate_divider #(
  parameter int W = 16,
  parameter int DEFAULT_DIV = 2
) (
  input logic clk,
  input logic reset,
  rate_divider_if.slave bus
);
  logic mode, s_mode, load_busy, tick, sq;
  logic [W-1:0] div, inc, s_div, s_inc, phase, d_eff;
  logic [W:0] sum;
  logic bypass, term, carry, boundary, apply;
  always_comb begin
    d_eff = (div == '0) ? W'(1) : div;
    bypass = div <= W'(1);
    term = bypass || (phase == d_eff - W'(1));
    sum = {1'b0, phase} + {1'b0, inc};
    carry = sum[W];
    boundary = bus.en && (mode ? carry : term);
    apply = load_busy && (boundary || bus.restart || !bus.en);
  end
  // The shadow read on an apply cycle is the old one, so a same-cycle load stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {mode, div, inc} <= {1'b0, W'(DEFAULT_DIV), W'(0)};
      {s_mode, s_div, s_inc} <= '0;
      {load_busy, tick, sq} <= '0;
      phase <= '0;
    end else begin
      if (bus.load) {s_mode, s_div, s_inc} <= {bus.mode_in, bus.div_in, bus.inc_in};
      load_busy <= bus.load || (load_busy && !apply);
      if (apply) {mode, div, inc} <= {s_mode, s_div, s_inc};
      if (bus.restart) begin
        phase <= '0;
        tick <= 1'b0;
        sq <= 1'b0;
      end else if (bus.en) begin
        tick <= mode ? carry : term;
        sq <= mode ? sum[W-1] : (bypass || (phase >= (d_eff >> 1)));
        phase <= apply ? '0 : mode ? sum[W-1:0] : term ? '0 : phase + W'(1);
      end else begin
        tick <= 1'b0;
        if (apply) phase <= '0;
      end
    end
  end
  assign bus.load_busy = load_busy;
  assign bus.tick = tick;
  assign bus.sq = sq;
  assign bus.phase = phase;
endmodule

// File: tb/tb_rate_divider.sv
// tb_rate_divider: directed scenario checks of rate_divider (DEFAULT_DIV = 3)
module tb_rate_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [15:0] ph6 [8];
  logic tk6 [8];
  rate_divider_if #(16) bus ();
  rate_divider #(.W(16), .DEFAULT_DIV(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_int(input logic [15:0] d);
    bus.load = 1'b1; bus.mode_in = 1'b0; bus.div_in = d; bus.inc_in = '0;
    step();
    bus.load = 1'b0;
  endtask

  task automatic load_frac(input logic [15:0] inc);
    bus.load = 1'b1; bus.mode_in = 1'b1; bus.div_in = '0; bus.inc_in = inc;
    step();
    bus.load = 1'b0;
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.restart = 1'b0; bus.load = 1'b0;
    bus.mode_in = 1'b0; bus.div_in = '0; bus.inc_in = '0;
    step();
    step();
    tests++;
    if (bus.phase !== 16'd0 || bus.tick !== 1'b0 || bus.sq !== 1'b0 || bus.load_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: phase=%0d tick=%b sq=%b busy=%b, want 0/0/0/0",
               bus.phase, bus.tick, bus.sq, bus.load_busy);
    end
  endtask

  task automatic test_default_div();
    bus.en = 1'b1;
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      tests++;
      if (bus.tick !== (c % 3 == 0) || bus.phase !== 16'(c % 3) || bus.sq !== ((c - 1) % 3 >= 1)) begin
        fails++;
        $display("FAIL default_div c=%0d: tick=%b phase=%0d sq=%b, want %b/%0d/%b",
                 c, bus.tick, bus.phase, bus.sq, c % 3 == 0, c % 3, (c - 1) % 3 >= 1);
      end
    end
    step();
    step();
    bus.en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++;
      if (bus.tick !== 1'b0 || bus.phase !== 16'd2 || bus.sq !== 1'b1) begin
        fails++;
        $display("FAIL en_low_hold c=%0d: tick=%b phase=%0d sq=%b, want 0/2/1",
                 c, bus.tick, bus.phase, bus.sq);
      end
    end
    bus.en = 1'b1;
    step();
    tests++;
    if (bus.tick !== 1'b1 || bus.phase !== 16'd0) begin
      fails++;
      $display("FAIL en_resume: tick=%b phase=%0d, want 1/0", bus.tick, bus.phase);
    end
  endtask

  task automatic test_bypass();
    load_int(16'd1);
    tests++;
    if (bus.load_busy !== 1'b1) begin
      fails++;
      $display("FAIL bypass_busy: load_busy=%b, want 1", bus.load_busy);
    end
    pulse_restart();
    tests++;
    if (bus.load_busy !== 1'b0 || bus.phase !== 16'd0 || bus.tick !== 1'b0 || bus.sq !== 1'b0) begin
      fails++;
      $display("FAIL restart_apply: busy=%b phase=%0d tick=%b sq=%b, want 0/0/0/0",
               bus.load_busy, bus.phase, bus.tick, bus.sq);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      tests++;
      if (bus.tick !== 1'b1 || bus.sq !== 1'b1 || bus.phase !== 16'd0) begin
        fails++;
        $display("FAIL div1 c=%0d: tick=%b sq=%b phase=%0d, want 1/1/0", c, bus.tick, bus.sq, bus.phase);
      end
    end
    load_int(16'd0);
    step();
    tests++;
    if (bus.load_busy !== 1'b0 || bus.tick !== 1'b1) begin
      fails++;
      $display("FAIL div0_apply: busy=%b tick=%b, want 0/1", bus.load_busy, bus.tick);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (bus.tick !== 1'b1 || bus.sq !== 1'b1) begin
        fails++;
        $display("FAIL div0 c=%0d: tick=%b sq=%b, want 1/1", c, bus.tick, bus.sq);
      end
    end
    bus.en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++;
      if (bus.tick !== 1'b0 || bus.phase !== 16'd0 || bus.sq !== 1'b1) begin
        fails++;
        $display("FAIL div0_en_low c=%0d: tick=%b phase=%0d sq=%b, want 0/0/1",
                 c, bus.tick, bus.phase, bus.sq);
      end
    end
  endtask

  task automatic test_fractional();
    int nticks;
    bus.en = 1'b1;
    load_frac(16'h4000);
    step();
    tests++;
    if (bus.load_busy !== 1'b0 || bus.phase !== 16'd0 || bus.tick !== 1'b1) begin
      fails++;
      $display("FAIL nco_apply: busy=%b phase=%h tick=%b, want 0/0000/1",
               bus.load_busy, bus.phase, bus.tick);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      tests++;
      if (bus.phase !== 16'(c * 16'h4000) || bus.tick !== (c % 4 == 0) || bus.sq !== ((c % 4) >= 2)) begin
        fails++;
        $display("FAIL nco4000 c=%0d: phase=%h tick=%b sq=%b, want %h/%b/%b",
                 c, bus.phase, bus.tick, bus.sq, 16'(c * 16'h4000), c % 4 == 0, (c % 4) >= 2);
      end
    end
    load_frac(16'h6000);
    step();
    step();
    tests++;
    if (bus.load_busy !== 1'b1 || bus.phase !== 16'hC000) begin
      fails++;
      $display("FAIL nco_pending: busy=%b phase=%h, want 1/c000", bus.load_busy, bus.phase);
    end
    step();
    tests++;
    if (bus.load_busy !== 1'b0 || bus.phase !== 16'd0 || bus.tick !== 1'b1) begin
      fails++;
      $display("FAIL nco_wrap_apply: busy=%b phase=%h tick=%b, want 0/0000/1",
               bus.load_busy, bus.phase, bus.tick);
    end
    nticks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      nticks += int'(bus.tick);
      tests++;
      if (bus.phase !== ph6[c] || bus.tick !== tk6[c] || bus.sq !== ph6[c][15]) begin
        fails++;
        $display("FAIL nco6000 c=%0d: phase=%h tick=%b sq=%b, want %h/%b/%b",
                 c, bus.phase, bus.tick, bus.sq, ph6[c], tk6[c], ph6[c][15]);
      end
    end
    tests++;
    if (nticks !== 3) begin
      fails++;
      $display("FAIL nco6000_count: ticks=%0d, want 3", nticks);
    end
  endtask

  task automatic test_back_to_back();
    load_int(16'd5);
    pulse_restart();
    step();
    load_int(16'd2);
    for (int c = 2; c <= 4; c++) begin
      tests++;
      if (bus.load_busy !== 1'b1 || bus.phase !== 16'(c) || bus.tick !== 1'b0) begin
        fails++;
        $display("FAIL d5_pending c=%0d: busy=%b phase=%0d tick=%b, want 1/%0d/0",
                 c, bus.load_busy, bus.phase, bus.tick, c);
      end
      if (c < 4) step();
    end
    step();
    tests++;
    if (bus.load_busy !== 1'b0 || bus.phase !== 16'd0 || bus.tick !== 1'b1) begin
      fails++;
      $display("FAIL d5_end_apply: busy=%b phase=%0d tick=%b, want 0/0/1",
               bus.load_busy, bus.phase, bus.tick);
    end
    load_int(16'd3);
    bus.load = 1'b1; bus.mode_in = 1'b0; bus.div_in = 16'd7;
    step();
    bus.load = 1'b0;
    tests++;
    if (bus.load_busy !== 1'b1 || bus.tick !== 1'b1 || bus.phase !== 16'd0) begin
      fails++;
      $display("FAIL b2b_apply: busy=%b tick=%b phase=%0d, want 1/1/0",
               bus.load_busy, bus.tick, bus.phase);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++;
      if (bus.tick !== (c == 3) || bus.load_busy !== (c < 3)) begin
        fails++;
        $display("FAIL d3_period c=%0d: tick=%b busy=%b, want %b/%b",
                 c, bus.tick, bus.load_busy, c == 3, c < 3);
      end
    end
    for (int c = 1; c <= 7; c++) begin
      step();
      tests++;
      if (bus.tick !== (c == 7) || bus.phase !== 16'(c % 7)) begin
        fails++;
        $display("FAIL d7_period c=%0d: tick=%b phase=%0d, want %b/%0d",
                 c, bus.tick, bus.phase, c == 7, c % 7);
      end
    end
  endtask

  task automatic test_stall_restart();
    load_frac(16'h0000);
    pulse_restart();
    load_int(16'd4);
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (bus.load_busy !== 1'b1 || bus.tick !== 1'b0 || bus.phase !== 16'd0) begin
        fails++;
        $display("FAIL inc0_stall c=%0d: busy=%b tick=%b phase=%0d, want 1/0/0",
                 c, bus.load_busy, bus.tick, bus.phase);
      end
    end
    pulse_restart();
    tests++;
    if (bus.load_busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_restart: busy=%b, want 0", bus.load_busy);
    end
    for (int c = 1; c <= 8; c++) begin
      step();
      tests++;
      if (bus.tick !== (c % 4 == 0) || bus.phase !== 16'(c % 4)) begin
        fails++;
        $display("FAIL d4_period c=%0d: tick=%b phase=%0d, want %b/%0d",
                 c, bus.tick, bus.phase, c % 4 == 0, c % 4);
      end
    end
  endtask

  task automatic test_async_reset();
    step();
    load_int(16'd9);
    step();
    tests++;
    if (bus.phase !== 16'd3 || bus.load_busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: phase=%0d busy=%b, want 3/1", bus.phase, bus.load_busy);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.phase !== 16'd0 || bus.tick !== 1'b0 || bus.load_busy !== 1'b0 || bus.sq !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: phase=%0d tick=%b busy=%b sq=%b, want 0/0/0/0",
               bus.phase, bus.tick, bus.load_busy, bus.sq);
    end
    step();
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      tests++;
      if (bus.tick !== (c % 3 == 0) || bus.load_busy !== 1'b0) begin
        fails++;
        $display("FAIL post_reset_div c=%0d: tick=%b busy=%b, want %b/0",
                 c, bus.tick, bus.load_busy, c % 3 == 0);
      end
    end
  endtask

  initial begin
    ph6 = '{16'h6000, 16'hC000, 16'h2000, 16'h8000, 16'hE000, 16'h4000, 16'hA000, 16'h0000};
    tk6 = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    test_reset();
    test_default_div();
    test_bypass();
    test_fractional();
    test_back_to_back();
    test_stall_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
